time_mode_controller: RTL and testbench

- Sequencing FSM for the alarm clock's time and alarm counter banks.
- Toggles between run mode and adjust mode.
- Steps through the four adjustable fields and issues single-cycle increment/decrement strobes to the selected field's up/down counter.
- Detects alarm match and drives the buzzer with a timeout.
- Sits between the button debouncers and the time/alarm counter datapath.

---
 rtl/time_mode_controller_pkg.sv | 22 ++
 rtl/time_mode_controller_if.sv | 32 +++
 rtl/time_mode_controller_alarm_match_detector.sv | 28 ++
 rtl/time_mode_controller.sv | 93 +++++++++
 tb/tb_time_mode_controller.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/time_mode_controller_pkg.sv
// time_mode_controller_pkg: shared states, field codes and packed H1/H2/M1/M2 layout.
package time_mode_controller_pkg;

    typedef enum logic [1:0] {RUN, ADJ, RING} state_t;

    localparam logic [1:0] FLD_TH = 2'd0;
    localparam logic [1:0] FLD_TM = 2'd1;
    localparam logic [1:0] FLD_AH = 2'd2;
    localparam logic [1:0] FLD_AM = 2'd3;

    localparam int H1_W = 2;
    localparam int H2_W = 4;
    localparam int M1_W = 3;
    localparam int M2_W = 4;
    localparam int HM_W = H1_W + H2_W + M1_W + M2_W;

    function automatic logic [HM_W-1:0] pack_hm(input logic [H1_W-1:0] h1, input logic [H2_W-1:0] h2,
                                                input logic [M1_W-1:0] m1, input logic [M2_W-1:0] m2);
        return {h1, h2, m1, m2};
    endfunction

endpackage

// File: rtl/time_mode_controller_if.sv
// time_mode_controller_if: buttons, time compare inputs and field/buzzer outputs of the controller.
interface time_mode_controller_if import time_mode_controller_pkg::*; #(parameter int SEL_W = 2) ();

    logic              tick_1hz;
    logic              btn_c;
    logic              btn_l;
    logic              btn_r;
    logic              btn_u;
    logic              btn_d;
    logic              alarm_sw;
    logic [HM_W-1:0]   cur_hm;
    logic [HM_W-1:0]   alm_hm;
    logic              cur_sec_zero;
    logic              run_en;
    logic              adj_mode;
    logic [SEL_W-1:0]  field_sel;
    logic [3:0]        fld_en;
    logic              fld_dn;
    logic              buzz;
    logic [3:0]        leds;

    modport master (
        output tick_1hz, btn_c, btn_l, btn_r, btn_u, btn_d, alarm_sw, cur_hm, alm_hm, cur_sec_zero,
        input  run_en, adj_mode, field_sel, fld_en, fld_dn, buzz, leds
    );

    modport slave (
        input  tick_1hz, btn_c, btn_l, btn_r, btn_u, btn_d, alarm_sw, cur_hm, alm_hm, cur_sec_zero,
        output run_en, adj_mode, field_sel, fld_en, fld_dn, buzz, leds
    );

endinterface

// File: rtl/time_mode_controller_alarm_match_detector.sv
// alarm_match_detector: one-cycle match pulse on the qualifying tick, held off until the minute changes.
module alarm_match_detector import time_mode_controller_pkg::*; (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            tick_i,
    input  logic            alarm_sw_i,
    input  logic [HM_W-1:0] cur_hm_i,
    input  logic [HM_W-1:0] alm_hm_i,
    input  logic            sec_zero_i,
    output logic            match_o
);

    logic eq;
    logic armed_q;
    logic armed_d;

    assign eq      = cur_hm_i == alm_hm_i;
    assign match_o = en_i && eq && sec_zero_i && tick_i && alarm_sw_i && !armed_q;
    // The latch survives the whole matching minute so a dismissed or timed-out alarm stays quiet.
    assign armed_d = eq && (armed_q || match_o);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) armed_q <= 1'b0;
        else      armed_q <= armed_d;
    end

endmodule

// File: rtl/time_mode_controller.sv
// time_mode_controller: RUN/ADJ/RING sequencer driving field strobes and the alarm buzzer.
module time_mode_controller import time_mode_controller_pkg::*; #(
    parameter int RING_TICKS = 60,
    parameter int SEL_W      = 2
) (
    input  logic clk,
    input  logic rst,
    time_mode_controller_if.slave bus
);

    localparam int CNT_W = $clog2(RING_TICKS + 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [3:0]       fld_en_q, fld_en_d;
    logic             fld_dn_q, fld_dn_d;
    logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;
    logic             match;

    alarm_match_detector u_match (
        .clk        (clk),
        .rst        (rst),
        .en_i       (state_q == RUN && !bus.btn_c),
        .tick_i     (bus.tick_1hz),
        .alarm_sw_i (bus.alarm_sw),
        .cur_hm_i   (bus.cur_hm),
        .alm_hm_i   (bus.alm_hm),
        .sec_zero_i (bus.cur_sec_zero),
        .match_o    (match)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        fld_en_d   = '0;
        fld_dn_d   = 1'b0;
        ring_cnt_d = ring_cnt_q;
        case (state_q)
            RUN: begin
                if (bus.btn_c) begin
                    state_d = ADJ;
                    sel_d   = SEL_W'(FLD_TH);
                end else if (match) begin
                    state_d    = RING;
                    ring_cnt_d = '0;
                end
            end
            ADJ: begin
                if (bus.btn_c) state_d = RUN;
                else if (bus.btn_u) fld_en_d = 4'(1) << sel_q;
                else if (bus.btn_d) begin
                    fld_en_d = 4'(1) << sel_q;
                    fld_dn_d = 1'b1;
                end
                else if (bus.btn_r) sel_d = sel_q + SEL_W'(1);
                else if (bus.btn_l) sel_d = sel_q - SEL_W'(1);
            end
            RING: begin
                if (bus.btn_c || !bus.alarm_sw || (bus.tick_1hz && ring_cnt_q >= CNT_W'(RING_TICKS - 1)))
                    state_d = RUN;
                else if (bus.tick_1hz && ring_cnt_q != CNT_W'(RING_TICKS))
                    ring_cnt_d = ring_cnt_q + CNT_W'(1);
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            sel_q      <= SEL_W'(FLD_TH);
            fld_en_q   <= '0;
            fld_dn_q   <= 1'b0;
            ring_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            fld_en_q   <= fld_en_d;
            fld_dn_q   <= fld_dn_d;
            ring_cnt_q <= ring_cnt_d;
        end
    end

    // Mode outputs decode straight from the state register so reset clears them without a clock.
    assign bus.run_en    = state_q != ADJ;
    assign bus.adj_mode  = state_q == ADJ;
    assign bus.buzz      = state_q == RING;
    assign bus.field_sel = sel_q;
    assign bus.fld_en    = fld_en_q;
    assign bus.fld_dn    = fld_dn_q;
    assign bus.leds      = (state_q == ADJ) ? 4'(1) << sel_q : 4'd0;

endmodule

// File: tb/tb_time_mode_controller.sv
// tb_time_mode_controller: table vectors, alarm corner sequences and random stimulus against a reference model.
module tb_time_mode_controller;
    import time_mode_controller_pkg::*;

    localparam int RT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passed = 0;
    int   total  = 0;

    time_mode_controller_if #(.SEL_W(2)) bus ();

    time_mode_controller #(.RING_TICKS(RT), .SEL_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=running, 1=adjusting, 2=ringing.
    int       m_mode;
    int       m_sel;
    bit       m_armed;
    int       m_ticks;
    bit [3:0] m_en;
    bit       m_dn;

    typedef struct {
        bit       c, l, r, u, d;
        bit       e_adj;
        bit [1:0] e_sel;
        bit [3:0] e_en;
        bit       e_dn;
    } vec_t;

    vec_t tbl[18];

    logic [HM_W-1:0] t0730;
    logic [HM_W-1:0] t0731;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = 0; m_sel = 0; m_armed = 0; m_ticks = 0; m_en = 0; m_dn = 0;
    endtask

    task automatic model_step();
        bit eq, fire;
        eq   = bus.cur_hm == bus.alm_hm;
        fire = m_mode == 0 && !bus.btn_c && eq && bus.cur_sec_zero && bus.tick_1hz && bus.alarm_sw && !m_armed;
        m_armed = eq && (m_armed || fire);
        m_en = 0;
        m_dn = 0;
        if (m_mode == 0) begin
            if (bus.btn_c) begin m_mode = 1; m_sel = 0; end
            else if (fire) begin m_mode = 2; m_ticks = 0; end
        end else if (m_mode == 1) begin
            if (bus.btn_c) m_mode = 0;
            else if (bus.btn_u) m_en = 4'(1 << m_sel);
            else if (bus.btn_d) begin m_en = 4'(1 << m_sel); m_dn = 1; end
            else if (bus.btn_r) m_sel = (m_sel + 1) % 4;
            else if (bus.btn_l) m_sel = (m_sel + 3) % 4;
        end else begin
            if (bus.btn_c || !bus.alarm_sw) m_mode = 0;
            else if (bus.tick_1hz) begin
                m_ticks++;
                if (m_ticks >= RT) m_mode = 0;
            end
        end
    endtask

    task automatic model_chk(input string name);
        logic [13:0] exp, act;
        exp = {m_mode != 1, m_mode == 1, 2'(m_sel), m_en, m_dn, m_mode == 2,
               (m_mode == 1) ? 4'(1 << m_sel) : 4'd0};
        act = {bus.run_en, bus.adj_mode, bus.field_sel, bus.fld_en, bus.fld_dn, bus.buzz, bus.leds};
        chk(name, 32'(act), 32'(exp));
    endtask

    task automatic step(input bit c, l, r, u, d, tick);
        bus.btn_c = c; bus.btn_l = l; bus.btn_r = r; bus.btn_u = u; bus.btn_d = d;
        bus.tick_1hz = tick;
        model_step();
        @(posedge clk);
        #1;
        model_chk("model");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick_step();
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic rearm();
        bus.cur_hm = t0731;
        idle(1);
        bus.cur_hm = t0730;
        tick_step();
    endtask

    initial begin
        t0730 = pack_hm(2'd0, 4'd7, 3'd3, 4'd0);
        t0731 = pack_hm(2'd0, 4'd7, 3'd3, 4'd1);
        tbl[0]  = '{1,0,0,0,0, 1, 2'd0, 4'b0000, 0};
        tbl[1]  = '{0,0,1,0,0, 1, 2'd1, 4'b0000, 0};
        tbl[2]  = '{0,0,1,0,0, 1, 2'd2, 4'b0000, 0};
        tbl[3]  = '{0,0,1,0,0, 1, 2'd3, 4'b0000, 0};
        tbl[4]  = '{0,0,1,0,0, 1, 2'd0, 4'b0000, 0};
        tbl[5]  = '{0,0,1,0,0, 1, 2'd1, 4'b0000, 0};
        tbl[6]  = '{0,1,0,0,0, 1, 2'd0, 4'b0000, 0};
        tbl[7]  = '{0,0,1,0,0, 1, 2'd1, 4'b0000, 0};
        tbl[8]  = '{0,0,1,0,0, 1, 2'd2, 4'b0000, 0};
        tbl[9]  = '{0,0,0,1,0, 1, 2'd2, 4'b0100, 0};
        tbl[10] = '{0,0,0,0,0, 1, 2'd2, 4'b0000, 0};
        tbl[11] = '{0,0,0,0,1, 1, 2'd2, 4'b0100, 1};
        tbl[12] = '{0,0,0,0,0, 1, 2'd2, 4'b0000, 0};
        tbl[13] = '{0,0,0,1,1, 1, 2'd2, 4'b0100, 0};
        tbl[14] = '{0,0,1,1,0, 1, 2'd2, 4'b0100, 0};
        tbl[15] = '{0,1,1,0,0, 1, 2'd3, 4'b0000, 0};
        tbl[16] = '{1,0,0,1,0, 0, 2'd3, 4'b0000, 0};
        tbl[17] = '{0,0,0,1,0, 0, 2'd3, 4'b0000, 0};

        bus.btn_c = 0; bus.btn_l = 0; bus.btn_r = 0; bus.btn_u = 0; bus.btn_d = 0;
        bus.tick_1hz = 0; bus.alarm_sw = 0; bus.cur_sec_zero = 0;
        bus.cur_hm = t0731; bus.alm_hm = t0730;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_outputs", {27'd0, bus.run_en, bus.buzz, bus.adj_mode, bus.field_sel},
            {27'd0, 1'b1, 1'b0, 1'b0, 2'd0});
        chk("reset_fld_en", 32'(bus.fld_en), 32'd0);

        foreach (tbl[i]) begin
            step(tbl[i].c, tbl[i].l, tbl[i].r, tbl[i].u, tbl[i].d, 0);
            chk($sformatf("vec%0d", i), {24'd0, bus.adj_mode, bus.field_sel, bus.fld_en, bus.fld_dn},
                {24'd0, tbl[i].e_adj, tbl[i].e_sel, tbl[i].e_en, tbl[i].e_dn});
        end

        // Alarm ring, timeout after RT ticks, no re-ring inside the same minute.
        bus.alarm_sw = 1; bus.cur_sec_zero = 1; bus.cur_hm = t0730;
        tick_step();
        chk("ring_start", 32'(bus.buzz), 32'd1);
        idle(2);
        tick_step();
        tick_step();
        chk("ring_tick2", 32'(bus.buzz), 32'd1);
        tick_step();
        chk("ring_timeout", 32'(bus.buzz), 32'd0);
        tick_step();
        chk("no_rering", 32'(bus.buzz), 32'd0);

        rearm();
        chk("ring_again", 32'(bus.buzz), 32'd1);
        step(1, 0, 0, 0, 0, 0);
        chk("dismiss_c", {30'd0, bus.buzz, bus.adj_mode}, 32'd0);

        rearm();
        chk("ring_third", 32'(bus.buzz), 32'd1);
        bus.alarm_sw = 0;
        idle(1);
        chk("dismiss_sw", 32'(bus.buzz), 32'd0);

        bus.alarm_sw = 1;
        rearm();
        chk("ring_fourth", 32'(bus.buzz), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst", {29'd0, bus.buzz, bus.run_en, bus.adj_mode}, {29'd0, 1'b0, 1'b1, 1'b0});
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.cur_hm = t0731;
        idle(1);
        chk("post_rst", {30'd0, bus.buzz, bus.adj_mode}, 32'd0);

        for (int i = 0; i < 600; i++) begin
            bus.alarm_sw     = $urandom_range(0, 9) != 0;
            bus.cur_sec_zero = $urandom_range(0, 3) != 0;
            bus.cur_hm       = $urandom_range(0, 2) != 0 ? t0730 : t0731;
            step($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
